// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : run_monitor
// Purpose  : Run-control monitor: finish-store detect, cycle budget, PC breakpoints
// Revision : 1.0  initial release
// ============================================================================
module run_monitor #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_BP      = 2,
  parameter int                CNT_W       = 32,
  parameter logic [DATA_W-1:0] FINISH_ADDR = DATA_W'(32'h0000_7fff),
  parameter int                MAX_CYCLES  = 100000,
  parameter bit                BP_EDGE     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        daddr,
  input  logic [DATA_W-1:0]        ddataout,
  input  logic                     we,
  input  logic [NUM_BP*DATA_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     running,
  output logic                     done,
  output logic                     timeout,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [DATA_W-1:0]        finish_data,
  output logic [DATA_W-1:0]        finish_pc,
  output logic [NUM_BP*CNT_W-1:0]  bp_hits,
  output logic [NUM_BP-1:0]        bp_pulse
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  // Budget compare done in a 64-bit domain so a narrow counter never aliases the limit
  localparam logic [63:0]      C_LAST    = 64'(MAX_CYCLES) - 64'd1;

  state_t              r_state;
  logic                r_running;
  logic                r_done;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_cycle_count;
  logic [DATA_W-1:0]   r_finish_data;
  logic [DATA_W-1:0]   r_finish_pc;

  logic                w_fin;
  logic                w_last;
  logic [CNT_W-1:0]    w_cnt_next;

  assign w_fin      = we & (daddr == FINISH_ADDR);
  assign w_last     = (64'(r_cycle_count) == C_LAST);
  assign w_cnt_next = (r_cycle_count == C_CNT_MAX) ? r_cycle_count : r_cycle_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_finish_data <= '0;
      r_finish_pc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          r_cycle_count <= w_cnt_next;
          // The finish store takes priority over budget expiry in the same cycle
          if (w_fin) begin
            r_state       <= S_DONE;
            r_running     <= 1'b0;
            r_done        <= 1'b1;
            r_finish_data <= ddataout;
            r_finish_pc   <= pc;
          end else if (w_last) begin
            r_state   <= S_TIMEOUT;
            r_running <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign running     = r_running;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;
  assign finish_data = r_finish_data;
  assign finish_pc   = r_finish_pc;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    logic             w_match;
    logic             w_hit;
    logic             r_prev;
    logic             r_pulse;
    logic [CNT_W-1:0] r_hits;

    assign w_match = bp_en[i] & (pc == bp_addr[i*DATA_W +: DATA_W]);
    assign w_hit   = w_match & (~BP_EDGE | ~r_prev);

    // r_prev is held clear outside RUN so every run starts with no prior match
    always_ff @(posedge clk) begin
      if (rst) begin
        r_prev  <= 1'b0;
        r_pulse <= 1'b0;
        r_hits  <= '0;
      end else if (r_state == S_RUN) begin
        r_prev  <= w_match;
        r_pulse <= w_hit;
        if (w_hit && (r_hits != C_CNT_MAX)) begin
          r_hits <= r_hits + 1'b1;
        end
      end else begin
        r_prev  <= 1'b0;
        r_pulse <= 1'b0;
      end
    end

    assign bp_hits[i*CNT_W +: CNT_W] = r_hits;
    assign bp_pulse[i]               = r_pulse;
  end

endmodule
`default_nettype wire

// File: tb/tb_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_monitor
// Purpose  : Self-checking bench for run_monitor against a behavioural model
// Revision : 1.0  initial release
// ============================================================================
module tb_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, we;
  logic [31:0] pc, daddr, ddataout;
  logic [63:0] bp_addr;
  logic [1:0]  bp_en;

  logic        a_run, a_done, a_to, b_run, b_done, b_to, c_run, c_done, c_to;
  logic [31:0] a_cnt, a_fd, a_fpc, b_cnt, b_fd, b_fpc, c_fd, c_fpc;
  logic [3:0]  c_cnt;
  logic [63:0] a_hits, b_hits;
  logic [7:0]  c_hits;
  logic [1:0]  a_pulse, b_pulse, c_pulse;

  // a: level breakpoints, b: edge breakpoints, c: 4-bit counters
  run_monitor #(.NUM_BP(2), .CNT_W(32), .MAX_CYCLES(50), .BP_EDGE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .daddr(daddr), .ddataout(ddataout),
    .we(we), .bp_addr(bp_addr), .bp_en(bp_en), .running(a_run), .done(a_done),
    .timeout(a_to), .cycle_count(a_cnt), .finish_data(a_fd), .finish_pc(a_fpc),
    .bp_hits(a_hits), .bp_pulse(a_pulse));
  run_monitor #(.NUM_BP(2), .CNT_W(32), .MAX_CYCLES(50), .BP_EDGE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .daddr(daddr), .ddataout(ddataout),
    .we(we), .bp_addr(bp_addr), .bp_en(bp_en), .running(b_run), .done(b_done),
    .timeout(b_to), .cycle_count(b_cnt), .finish_data(b_fd), .finish_pc(b_fpc),
    .bp_hits(b_hits), .bp_pulse(b_pulse));
  run_monitor #(.NUM_BP(2), .CNT_W(4), .MAX_CYCLES(1000), .BP_EDGE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .daddr(daddr), .ddataout(ddataout),
    .we(we), .bp_addr(bp_addr), .bp_en(bp_en), .running(c_run), .done(c_done),
    .timeout(c_to), .cycle_count(c_cnt), .finish_data(c_fd), .finish_pc(c_fpc),
    .bp_hits(c_hits), .bp_pulse(c_pulse));

  logic        o_run [3], o_done [3], o_to [3];
  logic [63:0] o_cnt [3];
  logic [63:0] o_hits [3][2];
  logic [1:0]  o_pulse [3];
  logic [31:0] o_fd [3], o_fpc [3];

  assign o_run[0] = a_run;  assign o_done[0] = a_done; assign o_to[0] = a_to;
  assign o_run[1] = b_run;  assign o_done[1] = b_done; assign o_to[1] = b_to;
  assign o_run[2] = c_run;  assign o_done[2] = c_done; assign o_to[2] = c_to;
  assign o_cnt[0] = 64'(a_cnt); assign o_cnt[1] = 64'(b_cnt); assign o_cnt[2] = 64'(c_cnt);
  assign o_fd[0] = a_fd; assign o_fd[1] = b_fd; assign o_fd[2] = c_fd;
  assign o_fpc[0] = a_fpc; assign o_fpc[1] = b_fpc; assign o_fpc[2] = c_fpc;
  assign o_pulse[0] = a_pulse; assign o_pulse[1] = b_pulse; assign o_pulse[2] = c_pulse;
  assign o_hits[0][0] = 64'(a_hits[31:0]); assign o_hits[0][1] = 64'(a_hits[63:32]);
  assign o_hits[1][0] = 64'(b_hits[31:0]); assign o_hits[1][1] = 64'(b_hits[63:32]);
  assign o_hits[2][0] = 64'(c_hits[3:0]);  assign o_hits[2][1] = 64'(c_hits[7:4]);

  // Reference model: 0 idle, 1 run, 2 done, 3 timeout
  int          m_state [3];
  longint      m_cnt [3];
  longint      m_hits [3][2];
  bit          m_pulse [3][2], m_prev [3][2];
  logic [31:0] m_fd [3], m_fpc [3];
  longint      m_max [3] = '{50, 50, 1000};
  bit          m_edge [3] = '{1'b0, 1'b1, 1'b0};
  longint      m_sat [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void model_edge();
    bit fin, m, hit;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_state[k] = 0; m_cnt[k] = 0; m_fd[k] = '0; m_fpc[k] = '0;
        for (int c = 0; c < 2; c++) begin
          m_hits[k][c] = 0; m_pulse[k][c] = 1'b0; m_prev[k][c] = 1'b0;
        end
      end else if (m_state[k] == 1) begin
        fin = we && (daddr == 32'h0000_7fff);
        for (int c = 0; c < 2; c++) begin
          m   = bp_en[c] && (pc == bp_addr[c*32 +: 32]);
          hit = m && (!m_edge[k] || !m_prev[k][c]);
          m_prev[k][c]  = m;
          m_pulse[k][c] = hit;
          if (hit && m_hits[k][c] < m_sat[k]) m_hits[k][c]++;
        end
        if (fin) begin
          m_state[k] = 2; m_fd[k] = ddataout; m_fpc[k] = pc;
        end else if (m_cnt[k] == m_max[k] - 1) begin
          m_state[k] = 3;
        end
        if (m_cnt[k] < m_sat[k]) m_cnt[k]++;
      end else begin
        if (m_state[k] == 0 && start) m_state[k] = 1;
        for (int c = 0; c < 2; c++) begin
          m_pulse[k][c] = 1'b0; m_prev[k][c] = 1'b0;
        end
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] rpc();
    return 32'h30 + 32'($urandom_range(0, 3)) * 32'd4;
  endfunction

  function automatic logic [31:0] raddr_nofin();
    return 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; we = 1'b0; pc = '0; daddr = '0; ddataout = '0;
    bp_addr = '0; bp_en = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_run[k] !== 1'b0 || o_done[k] !== 1'b0 || o_to[k] !== 1'b0)
        $display("FAIL reset_flags dut%0d: got run/done/to=%b%b%b want 000", k, o_run[k], o_done[k], o_to[k]);
      else n_pass++;
      n_chk++; if (o_cnt[k] !== 64'd0 || o_fd[k] !== 32'd0 || o_fpc[k] !== 32'd0)
        $display("FAIL reset_regs dut%0d: got cnt=%0d fd=%h fpc=%h want 0", k, o_cnt[k], o_fd[k], o_fpc[k]);
      else n_pass++;
      n_chk++; if (o_hits[k][0] !== 64'd0 || o_hits[k][1] !== 64'd0 || o_pulse[k] !== 2'b00)
        $display("FAIL reset_bp dut%0d: got hits=%0d,%0d pulse=%b want 0", k, o_hits[k][0], o_hits[k][1], o_pulse[k]);
      else n_pass++;
    end
  endtask

  task automatic test_finish();
    logic [31:0] fin_pc;
    do_reset();
    bp_addr = {32'h34, 32'h30}; bp_en = 2'b11;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_run[k] !== 1'b1) $display("FAIL start_run dut%0d: got %b want 1", k, o_run[k]);
      else n_pass++;
    end
    fin_pc = '0;
    for (int n = 1; n <= 10; n++) begin
      pc = rpc();
      we = (n == 10) ? 1'b1 : 1'($urandom_range(0, 1));
      daddr = (n == 10) ? 32'h0000_7fff : raddr_nofin();
      ddataout = (n == 10) ? 32'h0000_002a : $urandom;
      if (n == 10) fin_pc = pc;
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_done[k] !== 1'b1 || o_to[k] !== 1'b0 || o_run[k] !== 1'b0)
        $display("FAIL finish_flags dut%0d: got done/to/run=%b%b%b want 100", k, o_done[k], o_to[k], o_run[k]);
      else n_pass++;
      n_chk++; if (o_cnt[k] !== 64'd10) $display("FAIL finish_cnt dut%0d: got %0d want 10", k, o_cnt[k]);
      else n_pass++;
      n_chk++; if (o_fd[k] !== 32'h2a || o_fpc[k] !== fin_pc)
        $display("FAIL finish_capture dut%0d: got fd=%h fpc=%h want 0000002a %h", k, o_fd[k], o_fpc[k], fin_pc);
      else n_pass++;
      n_chk++; if (o_hits[k][0] !== m_hits[k][0] || o_hits[k][1] !== m_hits[k][1])
        $display("FAIL finish_hits dut%0d: got %0d,%0d want %0d,%0d", k, o_hits[k][0], o_hits[k][1], m_hits[k][0], m_hits[k][1]);
      else n_pass++;
    end
    for (int n = 0; n < 20; n++) begin
      pc = rpc(); we = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      daddr = ($urandom_range(0, 1) == 1) ? 32'h0000_7fff : raddr_nofin();
      ddataout = $urandom;
      cyc();
      n_chk++; if (a_done !== 1'b1 || a_cnt !== 32'd10 || a_fd !== 32'h2a || a_fpc !== fin_pc || a_pulse !== 2'b00
                  || o_hits[0][0] !== m_hits[0][0] || o_hits[0][1] !== m_hits[0][1])
        $display("FAIL hold_done: got done=%b cnt=%0d fd=%h pulse=%b hits=%0d,%0d want 1 10 2a 00 %0d,%0d",
                 a_done, a_cnt, a_fd, a_pulse, o_hits[0][0], o_hits[0][1], m_hits[0][0], m_hits[0][1]);
      else n_pass++;
    end
    start = 1'b0; we = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      pc = rpc(); we = 1'($urandom_range(0, 1)); daddr = raddr_nofin(); ddataout = $urandom;
      cyc();
      if (n == 49) begin
        n_chk++; if (a_to !== 1'b0 || a_run !== 1'b1) $display("FAIL pre_timeout: got to/run=%b%b want 01", a_to, a_run);
        else n_pass++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (o_to[k] !== 1'b1 || o_done[k] !== 1'b0 || o_run[k] !== 1'b0 || o_cnt[k] !== 64'd50)
        $display("FAIL timeout dut%0d: got to/done/run=%b%b%b cnt=%0d want 100 50", k, o_to[k], o_done[k], o_run[k], o_cnt[k]);
      else n_pass++;
    end
    n_chk++; if (c_cnt !== 4'd15 || c_run !== 1'b1) $display("FAIL cnt_saturate: got cnt=%0d run=%b want 15 1", c_cnt, c_run);
    else n_pass++;

    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      pc = rpc(); we = (n == 50) ? 1'b1 : 1'b0;
      daddr = (n == 50) ? 32'h0000_7fff : raddr_nofin(); ddataout = 32'h1234_5678;
      cyc();
    end
    we = 1'b0;
    n_chk++; if (a_done !== 1'b1 || a_to !== 1'b0 || a_cnt !== 32'd50 || a_fd !== 32'h1234_5678)
      $display("FAIL fin_at_expiry: got done/to=%b%b cnt=%0d fd=%h want 10 50 12345678", a_done, a_to, a_cnt, a_fd);
    else n_pass++;
  endtask

  task automatic test_bp_edge();
    logic [31:0] seq   [6] = '{32'h30, 32'h30, 32'h30, 32'h34, 32'h30, 32'h40};
    bit          exp_a [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bit          exp_b [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    bp_addr = {32'h100, 32'h30}; bp_en = 2'b01;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pc = seq[i]; cyc();
      n_chk++; if (a_pulse[0] !== exp_a[i] || b_pulse[0] !== exp_b[i])
        $display("FAIL bp_pulse step%0d: got level=%b edge=%b want %b %b", i, a_pulse[0], b_pulse[0], exp_a[i], exp_b[i]);
      else n_pass++;
    end
    n_chk++; if (a_hits[31:0] !== 32'd4) $display("FAIL bp_level_hits: got %0d want 4", a_hits[31:0]);
    else n_pass++;
    n_chk++; if (b_hits[31:0] !== 32'd2) $display("FAIL bp_edge_hits: got %0d want 2", b_hits[31:0]);
    else n_pass++;
  endtask

  task automatic test_two_channels();
    do_reset();
    bp_addr = {32'h30, 32'h30}; bp_en = 2'b01;
    start = 1'b1; cyc(); start = 1'b0;
    pc = 32'h30; cyc(); cyc();
    n_chk++; if (a_hits[31:0] !== 32'd2 || a_hits[63:32] !== 32'd0)
      $display("FAIL chan_en01: got %0d,%0d want 2,0", a_hits[31:0], a_hits[63:32]);
    else n_pass++;
    bp_en = 2'b11; cyc();
    n_chk++; if (a_hits[31:0] !== 32'd3 || a_hits[63:32] !== 32'd1 || a_pulse !== 2'b11)
      $display("FAIL chan_en11: got %0d,%0d pulse=%b want 3,1 11", a_hits[31:0], a_hits[63:32], a_pulse);
    else n_pass++;
    for (int n = 0; n < 50; n++) begin
      pc = rpc(); bp_en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bp_addr[63:32] = rpc();
      we = 1'($urandom_range(0, 1)); daddr = raddr_nofin();
      cyc();
      for (int k = 0; k < 3; k++) begin
        n_chk++; if (o_cnt[k] !== 64'(m_cnt[k]) || o_run[k] !== (m_state[k] == 1) || o_to[k] !== (m_state[k] == 3)
                    || o_hits[k][0] !== 64'(m_hits[k][0]) || o_hits[k][1] !== 64'(m_hits[k][1])
                    || o_pulse[k] !== {m_pulse[k][1], m_pulse[k][0]})
          $display("FAIL random_run dut%0d cyc%0d: got cnt=%0d run=%b to=%b hits=%0d,%0d pulse=%b want %0d st=%0d %0d,%0d %b%b",
                   k, n, o_cnt[k], o_run[k], o_to[k], o_hits[k][0], o_hits[k][1], o_pulse[k],
                   m_cnt[k], m_state[k], m_hits[k][0], m_hits[k][1], m_pulse[k][1], m_pulse[k][0]);
        else n_pass++;
      end
    end
    we = 1'b0;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    bp_addr = {32'h100, 32'h30}; bp_en = 2'b01;
    start = 1'b1; cyc(); start = 1'b0;
    pc = 32'h30;
    for (int n = 0; n < 6; n++) cyc();
    n_chk++; if (a_hits[31:0] !== 32'd6 || a_cnt !== 32'd6) $display("FAIL pre_rst: got hits=%0d cnt=%0d want 6 6", a_hits[31:0], a_cnt);
    else n_pass++;
    rst = 1'b1; cyc(); rst = 1'b0;
    n_chk++; if (a_run !== 1'b0 || a_cnt !== 32'd0 || a_hits !== 64'd0 || a_pulse !== 2'b00 || a_done !== 1'b0 || a_to !== 1'b0)
      $display("FAIL midrun_rst: got run=%b cnt=%0d hits=%h pulse=%b want all 0", a_run, a_cnt, a_hits, a_pulse);
    else n_pass++;
    start = 1'b1; cyc(); start = 1'b0;
    n_chk++; if (a_run !== 1'b1 || a_cnt !== 32'd0) $display("FAIL restart: got run=%b cnt=%0d want 1 0", a_run, a_cnt);
    else n_pass++;
    pc = 32'h0; cyc();
    n_chk++; if (a_cnt !== 32'd1) $display("FAIL restart_cnt: got %0d want 1", a_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    bp_addr = {32'h100, 32'h30}; bp_en = 2'b01;
    start = 1'b1; cyc(); start = 1'b0;
    pc = 32'h30;
    for (int n = 0; n < 20; n++) cyc();
    n_chk++; if (c_hits[3:0] !== 4'd15 || c_pulse[0] !== 1'b1 || a_hits[31:0] !== 32'd20)
      $display("FAIL hits_saturate: got c=%0d pulse=%b a=%0d want 15 1 20", c_hits[3:0], c_pulse[0], a_hits[31:0]);
    else n_pass++;
    we = 1'b0; daddr = 32'h0000_7fff; ddataout = 32'h55; cyc();
    n_chk++; if (c_done !== 1'b0 || c_run !== 1'b1) $display("FAIL we0_store: got done=%b run=%b want 0 1", c_done, c_run);
    else n_pass++;
    we = 1'b1; cyc(); we = 1'b0;
    n_chk++; if (c_done !== 1'b1 || c_fd !== 32'h55 || c_fpc !== 32'h30)
      $display("FAIL we1_store: got done=%b fd=%h fpc=%h want 1 55 30", c_done, c_fd, c_fpc);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_finish();
    test_timeout();
    test_bp_edge();
    test_two_channels();
    test_reset_midrun();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_monitor.md
# run_monitor

Synthesizable run-control and event monitor for the mipse core. It watches the instruction-fetch PC and the data-memory write port, detects the program's finish store, and enforces a cycle budget. It also counts hits on NUM_BP independently configurable PC breakpoints. It sits beside the core on the pc/aluresult/writedata/memwrite nets and gives benches and on-chip debug a registered status view: done/timeout flags, cycle count, finish value and per-channel hit counters.

## Interface

- DATA_W, 32, width of pc, daddr, ddataout
- NUM_BP, 2, number of PC breakpoint channels (≥1)
- CNT_W, 32, width of cycle and hit counters
- FINISH_ADDR, 32'h0000_7fff, data address whose store ends the run
- MAX_CYCLES, 100000, RUN-cycle budget before timeout (≥1, < 2^CNT_W)
- BP_EDGE, 0, 0 = count every matching cycle; 1 = count only the first cycle of each contiguous match

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin run; sampled in IDLE only
- pc  in  DATA_W  core fetch address
- daddr  in  DATA_W  data-memory address (core aluresult)
- ddataout  in  DATA_W  data-memory write data
- we  in  1  data-memory write enable
- bp_addr  in  NUM_BP*DATA_W  breakpoint PCs, channel i at [i*DATA_W +: DATA_W]
- bp_en  in  NUM_BP  per-channel enable
- running  out  1  state == RUN
- done  out  1  sticky, finish store seen
- timeout  out  1  sticky, budget exhausted
- cycle_count  out  CNT_W  RUN cycles elapsed
- finish_data  out  DATA_W  ddataout captured at finish
- finish_pc  out  DATA_W  pc captured at finish
- bp_hits  out  NUM_BP*CNT_W  per-channel hit counters
- bp_pulse  out  NUM_BP  one-cycle registered hit strobe

## Operation

- States: IDLE, RUN, DONE, TIMEOUT. Encoding is free.
- IDLE: start=1 → RUN. Otherwise hold. No counting.
- RUN, per cycle:
  - cycle_count increments by 1.
  - fin = we & (daddr == FINISH_ADDR), full DATA_W compare.
  - fin → DONE; finish_data ← ddataout, finish_pc ← pc.
  - else cycle_count == MAX_CYCLES-1 → TIMEOUT.
  - fin and budget expiry in the same cycle: DONE wins, timeout stays 0.
- DONE, TIMEOUT: terminal. start, we and pc are ignored. All outputs hold until rst.
- Breakpoints are evaluated in RUN only, including the terminating cycle. Channel i matches when bp_en[i] & (pc == bp_addr[i]).
  - BP_EDGE=0: every matching cycle counts. A stalled PC counts each cycle.
  - BP_EDGE=1: a match counts only if channel i did not match in the previous RUN cycle. The per-channel previous-match register is cleared on entry to RUN.
  - A counted hit increments bp_hits[i] and asserts bp_pulse[i] for the next cycle.
  - Channels are independent. Equal bp_addr on two channels makes both count.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Changing bp_en or bp_addr mid-run takes effect on the next compare cycle. Counts are not cleared.
- rst in any state, including mid-run: state IDLE, all counters and captures 0, prev-match registers 0.

## Timing

- Reset values: running=0, done=0, timeout=0, cycle_count=0, finish_data=0, finish_pc=0, bp_hits=0, bp_pulse=0.
- start sampled high at edge E: running=1 after E. The first counted RUN cycle is the one following E.
- Finish store present in RUN cycle N (N=1 first): after that edge, done=1, running=0, cycle_count=N.
- No finish: timeout=1 and cycle_count=MAX_CYCLES after the MAX_CYCLES-th RUN edge.
- bp_pulse and bp_hits update on the same edge that samples the match (one-cycle latency). bp_pulse drops the next cycle unless another hit is counted.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan

- Reset, then start, with FINISH_ADDR=7fff and a finish store of 0x0000_002a in RUN cycle 10 → done=1, timeout=0, cycle_count=10, finish_data=0000002a. Outputs are held for a further 20 cycles with random we/daddr.
- MAX_CYCLES=50, no finish store → timeout=1 after the 50th RUN edge, cycle_count=50, done=0. A finish store in the same cycle as expiry (MAX_CYCLES=50, fin in cycle 50) → done=1, timeout=0.
- BP_EDGE=0, bp_addr0=0x30, pc=0x30 held for 3 cycles, then 0x34, then 0x30 once → bp_hits0=4, bp_pulse0 high for 3 consecutive cycles, then once more. BP_EDGE=1 with the same stimulus → bp_hits0=2.
- Two channels, both at 0x30, bp_en=2'b01 → only channel 0 counts. Set bp_en=2'b11 mid-run → channel 1 starts counting on the next match.
- rst asserted in RUN cycle 7 after hits → all outputs 0, IDLE. A start in the next cycle begins a fresh run with cycle_count counting from 1.
- CNT_W=4, BP_EDGE=0, pc matching for 20 cycles → bp_hits0 saturates at 15. A write to FINISH_ADDR with we=0 does not finish.
